// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped TX FIFO with status/control registers, draining into uart_tx.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        FPGA_CLK,
  input  logic        RESET,
  input  logic        data_read_valid,
  input  logic        data_write_valid,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write,
  input  logic [3:0]  data_write_byte,
  output logic [31:0] data_read,
  output logic        data_ready,
  output logic        data_ack,
  output logic [7:0]  tx_data,
  output logic        tx_data_ready,
  input  logic        tx_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  typedef enum logic [1:0] {IDLE, OFFER, WAIT_BUSY} state_t;
  state_t state_q, state_d;
  logic [AW:0] wr_ptr_q, rd_ptr_q, count;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] tx_data_q;
  logic [31:0] rdata_q, rdata_d, status;
  logic [3:0] off;
  logic enable_q, ack_q;
  logic sel, wr_req, rd_req, full, empty, idle, accept, push, pop, flush, ctrl_wr;
  logic unused;
  assign unused = ^{data_write[31:8], data_write_byte[3:1]};
  assign off = data_addr[3:0];
  assign sel = (data_read_valid | data_write_valid) & (data_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_req = sel & data_write_valid;
  assign rd_req = sel & data_read_valid & !data_write_valid;
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign idle = empty & (state_q == IDLE) & tx_ready;
  // Stall only pushes into a full FIFO; full is registered so a same-cycle pop cannot unstall.
  assign data_ready = !(wr_req & (off == 4'h0) & data_write_byte[0] & full);
  assign accept = sel & data_ready;
  assign push = accept & wr_req & (off == 4'h0) & data_write_byte[0];
  assign ctrl_wr = accept & wr_req & (off == 4'h8);
  assign flush = ctrl_wr & data_write[1];
  // A flush on the same edge wins over a pop so no flushed byte can reach OFFER.
  assign pop = (state_q == IDLE) & !empty & enable_q & !flush;
  assign status = {16'd0, 8'(count), 5'd0, idle, empty, full};
  always_comb begin
    rdata_d = !(accept & rd_req) ? 32'd0 :
              (off == 4'h4) ? status :
              (off == 4'h8) ? {31'd0, enable_q} : 32'd0;
  end
  always_ff @(posedge FPGA_CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      enable_q  <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      tx_data_q <= '0;
    end else begin
      ack_q   <= accept;
      rdata_q <= rdata_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (flush) rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (ctrl_wr) enable_q <= data_write[0];
      if (pop) tx_data_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end
  always_ff @(posedge FPGA_CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_write[7:0];
  end
  always_ff @(posedge FPGA_CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = pop ? OFFER :
              (state_q == OFFER && tx_ready) ? WAIT_BUSY :
              (state_q == WAIT_BUSY && !tx_ready) ? IDLE : state_q;
  end
  always_comb begin
    tx_data_ready = state_q == OFFER;
    tx_data       = tx_data_q;
    data_ack      = ack_q;
    data_read     = rdata_q;
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: bus-driven bench with a uart_tx model popping an expected-byte scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h8000_0000;
  logic FPGA_CLK = 1'b0;
  logic RESET;
  logic data_read_valid, data_write_valid;
  logic [31:0] data_addr, data_write, data_read;
  logic [3:0] data_write_byte;
  logic data_ready, data_ack, tx_data_ready, tx_ready;
  logic [7:0] tx_data;
  int n_chk = 0, n_fail = 0, ack_cnt = 0, xfer_cnt = 0, last_stall = 0;
  bit hold = 1'b0;
  logic [7:0] exp_q[$];
  uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(16)) dut (
    .FPGA_CLK(FPGA_CLK), .RESET(RESET),
    .data_read_valid(data_read_valid), .data_write_valid(data_write_valid),
    .data_addr(data_addr), .data_write(data_write), .data_write_byte(data_write_byte),
    .data_read(data_read), .data_ready(data_ready), .data_ack(data_ack),
    .tx_data(tx_data), .tx_data_ready(tx_data_ready), .tx_ready(tx_ready)
  );
  always #5 FPGA_CLK = ~FPGA_CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic bus(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output int stalls);
    @(negedge FPGA_CLK);
    data_write_valid = wr;
    data_read_valid = !wr;
    data_addr = addr;
    data_write = wd;
    data_write_byte = be;
    stalls = 0;
    #1;
    while (!data_ready && stalls < 100) begin
      @(negedge FPGA_CLK);
      #1;
      stalls++;
    end
    if (!data_ready) chk("bus_stall_timeout", 32'(data_ready), 32'd1);
    @(posedge FPGA_CLK);
    #1;
    data_write_valid = 1'b0;
    data_read_valid = 1'b0;
    @(negedge FPGA_CLK);
    chk("ack", 32'(data_ack), 32'd1);
    rd = data_read;
  endtask
  task automatic wr(input logic [31:0] off, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] d;
    int s;
    bus(1'b1, BASE + off, wd, be, d, s);
    last_stall = s;
  endtask
  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    int s;
    bus(1'b0, BASE + off, 32'd0, 4'h0, d, s);
  endtask
  task automatic txw(input logic [7:0] b);
    exp_q.push_back(b);
    wr(32'h0, {24'd0, b}, 4'h1);
  endtask
  task automatic wait_drain(input int lim);
    int i = 0;
    while (exp_q.size() != 0 && i < lim) begin
      @(negedge FPGA_CLK);
      i++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask
  // uart_tx model: accepts when idle, then stays busy for ~10 cycles.
  initial begin
    int busy = 0;
    bit pend = 1'b0;
    tx_ready = 1'b1;
    forever begin
      @(negedge FPGA_CLK);
      if (hold) begin
        tx_ready = 1'b0;
        pend = 1'b0;
        busy = 0;
      end else if (pend) begin
        tx_ready = 1'b0;
        pend = 1'b0;
        busy = 9;
      end else if (busy > 0) begin
        busy--;
        tx_ready = (busy == 0);
      end else tx_ready = 1'b1;
      if (tx_ready && tx_data_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) chk("tx_extra_byte", 32'(exp_q.size()), 32'd1);
        else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        pend = 1'b1;
      end
    end
  end
  initial forever begin
    @(negedge FPGA_CLK);
    if (data_ack) ack_cnt++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [31:0] d;
    int a0, x0;
    RESET = 1'b0;
    data_read_valid = 1'b0;
    data_write_valid = 1'b0;
    data_addr = '0;
    data_write = '0;
    data_write_byte = '0;
    repeat (3) @(negedge FPGA_CLK);
    #1;
    chk("rst_data_ready", 32'(data_ready), 32'd1);
    chk("rst_tx_data_ready", 32'(tx_data_ready), 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_data_ack", 32'(data_ack), 32'd0);
    chk("rst_data_read", data_read, 32'd0);
    @(negedge FPGA_CLK);
    RESET = 1'b1;
    rd(32'h4, d); chk("rst_status", d, 32'h6);
    rd(32'h8, d); chk("rst_ctrl", d, 32'h1);
    // Three bytes through the live uart_tx model
    a0 = ack_cnt; x0 = xfer_cnt;
    txw(8'h48); txw(8'h69); txw(8'h0A);
    wait_drain(300);
    repeat (15) @(negedge FPGA_CLK);
    #1;
    chk("t1_acks", 32'(ack_cnt - a0), 32'd3);
    chk("t1_xfers", 32'(xfer_cnt - x0), 32'd3);
    rd(32'h4, d); chk("t1_status_idle", d, 32'h6);
    // Fill with the sink stalled, then overflow by one and release
    hold = 1'b1;
    repeat (2) @(negedge FPGA_CLK);
    a0 = ack_cnt; x0 = xfer_cnt;
    for (int i = 0; i < 17; i++) txw(8'hA0 + 8'(i));
    #2;
    chk("t2_acks", 32'(ack_cnt - a0), 32'd17);
    rd(32'h4, d); chk("t2_status_full", d, 32'h0000_1001);
    fork
      txw(8'hB1);
      begin
        repeat (4) @(negedge FPGA_CLK);
        #1;
        chk("t2_ready_low", 32'(data_ready), 32'd0);
        #1 hold = 1'b0;
      end
    join
    chk("t2_stall_range", 32'(last_stall >= 4 && last_stall <= 8), 32'd1);
    wait_drain(600);
    chk("t2_xfers", 32'(xfer_cnt - x0), 32'd18);
    repeat (15) @(negedge FPGA_CLK);
    // Disabled drain holds bytes until re-enabled
    x0 = xfer_cnt;
    wr(32'h8, 32'h0, 4'hF);
    txw(8'hC1); txw(8'hC2); txw(8'hC3);
    repeat (5) @(negedge FPGA_CLK);
    #1;
    chk("t3_no_offer", 32'(tx_data_ready), 32'd0);
    chk("t3_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    rd(32'h4, d); chk("t3_status_cnt3", d, 32'h0000_0300);
    wr(32'h8, 32'h1, 4'hF);
    @(posedge FPGA_CLK);
    #1;
    chk("t3_offer_after_enable", 32'(tx_data_ready), 32'd1);
    wait_drain(200);
    repeat (15) @(negedge FPGA_CLK);
    // Flush while the head byte is on offer
    hold = 1'b1;
    repeat (2) @(negedge FPGA_CLK);
    x0 = xfer_cnt;
    for (int i = 0; i < 5; i++) txw(8'hD1 + 8'(i));
    repeat (2) @(negedge FPGA_CLK);
    #1;
    chk("t4_offering", 32'(tx_data_ready), 32'd1);
    wr(32'h8, 32'h3, 4'hF);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    rd(32'h4, d); chk("t4_status_flushed", d, 32'h2);
    hold = 1'b0;
    wait_drain(100);
    repeat (30) @(negedge FPGA_CLK);
    #1;
    chk("t4_xfers", 32'(xfer_cnt - x0), 32'd1);
    chk("t4_no_more_offers", 32'(tx_data_ready), 32'd0);
    // Asynchronous reset during OFFER and an ack cycle
    hold = 1'b1;
    repeat (2) @(negedge FPGA_CLK);
    txw(8'hE1);
    repeat (3) @(negedge FPGA_CLK);
    wr(32'h8, 32'h0, 4'hF);
    rd(32'h4, d); chk("t5_status_pre", d, 32'h2);
    #1 RESET = 1'b0;
    #1;
    chk("t5_rst_tx_data_ready", 32'(tx_data_ready), 32'd0);
    chk("t5_rst_data_ack", 32'(data_ack), 32'd0);
    chk("t5_rst_data_read", data_read, 32'd0);
    exp_q.delete();
    hold = 1'b0;
    repeat (2) @(negedge FPGA_CLK);
    RESET = 1'b1;
    repeat (2) @(negedge FPGA_CLK);
    rd(32'h4, d); chk("t5_status_after", d, 32'h6);
    rd(32'h8, d); chk("t5_ctrl_after", d, 32'h1);
    // Unmapped offsets, read-only STATUS, masked TXDATA write, out-of-window access
    a0 = ack_cnt; x0 = xfer_cnt;
    rd(32'hC, d); chk("t6_rd_off_c", d, 32'h0);
    wr(32'h4, 32'hFFFF_FFFF, 4'hF);
    wr(32'h0, 32'h55, 4'hE);
    repeat (20) @(negedge FPGA_CLK);
    rd(32'h4, d); chk("t6_status_unchanged", d, 32'h6);
    chk("t6_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    @(negedge FPGA_CLK);
    data_read_valid = 1'b1;
    data_addr = BASE + 32'h10;
    repeat (3) @(negedge FPGA_CLK);
    data_read_valid = 1'b0;
    data_write_valid = 1'b1;
    data_write_byte = 4'hF;
    data_addr = 32'h0000_0000;
    repeat (3) @(negedge FPGA_CLK);
    data_write_valid = 1'b0;
    repeat (3) @(negedge FPGA_CLK);
    #1;
    chk("t6_acks", 32'(ack_cnt - a0), 32'd4);
    chk("t6_oow_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
